// File: rtl/atmega_pcint.sv
// Pin-change interrupt block: synchronizes the port pins, detects the
// selected edge/level per pin, latches per-pin flags and raises irq
// when an enabled, masked flag is pending. Register access is a simple
// single-cycle read/write bus with a combinational read mux.
module atmega_pcint #(
    parameter int unsigned                  BUS_ADDR_DATA_LEN = 8,
    parameter int unsigned                  PORT_WIDTH        = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PCICR_ADDR        = 'h68,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PCMSK_ADDR        = 'h6B,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PCIFR_ADDR        = 'h3B,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PCPIN_ADDR        = 'h3C,
    parameter logic [PORT_WIDTH-1:0]        PINMASK           = 'hFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [PORT_WIDTH-1:0]        bus_in,
    output logic [PORT_WIDTH-1:0]        bus_out,
    input  logic [PORT_WIDTH-1:0]        io_in,
    input  logic                         int_ack,
    output logic                         irq
);

    typedef enum logic [1:0] {
        MODE_ANY  = 2'b00,
        MODE_FALL = 2'b01,
        MODE_RISE = 2'b10,
        MODE_LOW  = 2'b11
    } mode_t;

    logic [PORT_WIDTH-1:0] s1, s2, s3;
    logic [PORT_WIDTH-1:0] pcmsk;
    logic [PORT_WIDTH-1:0] pcifr;
    logic                  en;
    mode_t                 mode;
    logic [1:0]            arm_cnt;
    logic                  armed;

    logic [PORT_WIDTH-1:0] rise, fall, low;
    logic [PORT_WIDTH-1:0] evt;
    logic [PORT_WIDTH-1:0] set_mask;
    logic [PORT_WIDTH-1:0] clr_mask;

    logic hit_pcicr, hit_pcmsk, hit_pcifr, hit_pcpin;

    assign hit_pcicr = (addr == PCICR_ADDR);
    assign hit_pcmsk = (addr == PCMSK_ADDR);
    assign hit_pcifr = (addr == PCIFR_ADDR);
    assign hit_pcpin = (addr == PCPIN_ADDR);

    // Two-flop synchronizer plus one history stage for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= io_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Arming counter: blocks flag setting until the synchronizer has
    // filled with real pin values, so pins high at release are not edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arm_cnt <= '0;
        end else if (arm_cnt != 2'd3) begin
            arm_cnt <= arm_cnt + 2'd1;
        end
    end

    assign armed = (arm_cnt == 2'd3);

    // Per-pin event selection according to the configured sense mode
    always_comb begin
        rise = s2 & ~s3;
        fall = ~s2 & s3;
        low  = ~s2;
        evt  = '0;
        case (mode)
            MODE_ANY:  evt = rise | fall;
            MODE_FALL: evt = fall;
            MODE_RISE: evt = rise;
            MODE_LOW:  evt = low;
            default:   evt = '0;
        endcase
    end

    // Flag set/clear sources; set is applied after clear so it wins
    always_comb begin
        set_mask = armed ? (evt & pcmsk & PINMASK) : '0;
        clr_mask = '0;
        if (wr && hit_pcifr) begin
            clr_mask = bus_in;
        end
        if (int_ack) begin
            clr_mask = '1;
        end
    end

    // Control, mask and flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en    <= 1'b0;
            mode  <= MODE_ANY;
            pcmsk <= '0;
            pcifr <= '0;
        end else begin
            pcifr <= ((pcifr & ~clr_mask) | set_mask) & PINMASK;
            if (wr && hit_pcicr) begin
                en   <= bus_in[0];
                mode <= mode_t'(bus_in[2:1]);
            end
            if (wr && hit_pcmsk) begin
                pcmsk <= bus_in & PINMASK;
            end
        end
    end

    assign irq = en & (|(pcifr & pcmsk));

    // Combinational read mux; idle bus and unmatched addresses read zero
    always_comb begin
        bus_out = '0;
        if (rd) begin
            if (hit_pcicr) begin
                bus_out = PORT_WIDTH'({mode, en});
            end else if (hit_pcmsk) begin
                bus_out = pcmsk;
            end else if (hit_pcifr) begin
                bus_out = pcifr;
            end else if (hit_pcpin) begin
                bus_out = s2 & PINMASK;
            end
        end
    end

endmodule
